// File: rtl/axil_ctrl_master.sv
// ---------------------------------------------------------------------------
// axil_ctrl_master
//
// AXI4-Lite initiator for a kernel control slave (ap_ctrl, GIE, IER, ISR and
// argument registers). It takes one command at a time from a valid/ready
// command stream and returns one response per command:
//   op 00 / 11 : single register read
//   op 01      : single register write (cmd_wdata / cmd_wstrb)
//   op 10      : bounded poll, repeated reads of cmd_addr until
//                (RDATA & cmd_wdata) != 0, with POLL_GAP idle cycles between
//                reads and a timeout after POLL_MAX reads
//
// Ports
//   ACLK, ARESET        clock, synchronous active-high reset
//   cmd_*               command stream (valid/ready), op/addr/wdata/wstrb
//   rsp_*               response stream (valid/ready), rdata/status/polls
//                       status: 00 OK, 01 AXI error, 10 poll timeout
//   AW*/W*/B*/AR*/R*    AXI4-Lite master channels
//
// Every output is driven straight from a flop, so no VALID depends
// combinationally on any READY.
// ---------------------------------------------------------------------------
module axil_ctrl_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 6,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned POLL_GAP           = 8,
    parameter int unsigned POLL_MAX           = 1024
) (
    input  logic                          ACLK,
    input  logic                          ARESET,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                   cmd_wdata,
    input  logic [3:0]                    cmd_wstrb,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_rdata,
    output logic [1:0]                    rsp_status,
    output logic [15:0]                   rsp_polls,

    output logic [C_M_AXI_ADDR_WIDTH-1:0] AWADDR,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] WDATA,
    output logic [3:0]                    WSTRB,
    output logic                          WVALID,
    input  logic                          WREADY,
    input  logic [1:0]                    BRESP,
    input  logic                          BVALID,
    output logic                          BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RVALID,
    output logic                          RREADY
);

    localparam int unsigned GapW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpPoll  = 2'b10;

    localparam logic [1:0] StatOk      = 2'b00;
    localparam logic [1:0] StatAxiErr  = 2'b01;
    localparam logic [1:0] StatTimeout = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StPollGap,
        StRsp
    } state_e;

    state_e                          state_q, state_d;
    logic                            cmd_ready_q, cmd_ready_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            bready_q, bready_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    // Write data for op 01, poll mask for op 10.
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]                      wstrb_q, wstrb_d;
    logic                            poll_q, poll_d;
    logic [31:0]                     rdata_q, rdata_d;
    logic [1:0]                      status_q, status_d;
    logic [15:0]                     polls_q, polls_d;
    logic [GapW-1:0]                 gap_cnt_q, gap_cnt_d;

    // A channel counts as finished once its VALID has dropped or it
    // handshakes this cycle; AW and W may complete in either order.
    logic aw_done, w_done;
    assign aw_done = !awvalid_q || AWREADY;
    assign w_done  = !wvalid_q || WREADY;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        poll_d      = poll_q;
        rdata_d     = rdata_q;
        status_d    = status_q;
        polls_d     = polls_q;
        gap_cnt_d   = gap_cnt_q;

        case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    poll_d      = (cmd_op == OpPoll);
                    polls_d     = 16'd0;
                    rdata_d     = 32'd0;
                    status_d    = StatOk;
                    if (cmd_op == OpWrite) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWrReq;
                    end else begin
                        // Reserved op 11 falls through to a plain read.
                        arvalid_d = 1'b1;
                        state_d   = StRdReq;
                    end
                end
            end

            StWrReq: begin
                if (AWREADY) awvalid_d = 1'b0;
                if (WREADY)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = StWrResp;
                end
            end

            StWrResp: begin
                if (BVALID) begin
                    bready_d    = 1'b0;
                    status_d    = (BRESP != 2'b00) ? StatAxiErr : StatOk;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end

            StRdReq: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    if (poll_q) polls_d = polls_q + 16'd1;
                    state_d   = StRdResp;
                end
            end

            StRdResp: begin
                if (RVALID) begin
                    rready_d = 1'b0;
                    rdata_d  = RDATA;
                    if (RRESP != 2'b00) begin
                        status_d    = StatAxiErr;
                        rsp_valid_d = 1'b1;
                        state_d     = StRsp;
                    end else if (!poll_q || ((RDATA & wdata_q) != '0)) begin
                        status_d    = StatOk;
                        rsp_valid_d = 1'b1;
                        state_d     = StRsp;
                    end else if (polls_q == 16'(POLL_MAX)) begin
                        status_d    = StatTimeout;
                        rsp_valid_d = 1'b1;
                        state_d     = StRsp;
                    end else if (POLL_GAP == 0) begin
                        arvalid_d = 1'b1;
                        state_d   = StRdReq;
                    end else begin
                        gap_cnt_d = GapW'(POLL_GAP);
                        state_d   = StPollGap;
                    end
                end
            end

            StPollGap: begin
                // The counter is loaded with POLL_GAP, so this state lasts
                // exactly POLL_GAP cycles.
                if (gap_cnt_q <= GapW'(1)) begin
                    arvalid_d = 1'b1;
                    state_d   = StRdReq;
                end else begin
                    gap_cnt_d = gap_cnt_q - GapW'(1);
                end
            end

            StRsp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            poll_q      <= 1'b0;
            rdata_q     <= '0;
            status_q    <= '0;
            polls_q     <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            poll_q      <= poll_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
            polls_q     <= polls_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;
    assign rsp_polls  = polls_q;

    assign AWADDR  = addr_q;
    assign AWVALID = awvalid_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WVALID  = wvalid_q;
    assign BREADY  = bready_q;
    assign ARADDR  = addr_q;
    assign ARVALID = arvalid_q;
    assign RREADY  = rready_q;

endmodule

// File: tb/tb_axil_ctrl_master.sv
// Directed bench for axil_ctrl_master with a small AXI4-Lite slave model.
module tb_axil_ctrl_master;

    localparam int AW   = 6;
    localparam int GAP  = 2;
    localparam int PMAX = 4;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_status;
    logic [15:0]   rsp_polls;
    logic [AW-1:0] AWADDR;
    logic          AWVALID;
    logic          AWREADY;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [AW-1:0] ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;

    axil_ctrl_master #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(32),
        .POLL_GAP(GAP),
        .POLL_MAX(PMAX)
    ) u_dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status), .rsp_polls(rsp_polls),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Slave configuration, set by the stimulus process.
    int          aw_delay = 0;
    int          r_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] rd_data [8];
    logic [1:0]  rd_resp [8];
    logic        mon_clr = 1'b0;

    // Slave model
    int   aw_cnt;
    logic got_aw, got_w;
    int   r_cnt;
    logic r_pend;
    int   r_idx;

    assign AWREADY = AWVALID && (aw_cnt >= aw_delay);
    assign WREADY  = 1'b1;
    assign ARREADY = 1'b1;

    always @(posedge ACLK) begin
        logic aw_ok, w_ok;
        if (ARESET) begin
            aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
            BVALID <= 1'b0; BRESP <= 2'b00;
            RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
            r_pend <= 1'b0; r_cnt <= 0; r_idx <= 0;
        end else begin
            if (AWVALID && AWREADY) aw_cnt <= 0;
            else if (AWVALID)       aw_cnt <= aw_cnt + 1;
            aw_ok = got_aw || (AWVALID && AWREADY);
            w_ok  = got_w || (WVALID && WREADY);
            if (BVALID && BREADY) BVALID <= 1'b0;
            if (aw_ok && w_ok && !BVALID) begin
                BVALID <= 1'b1; BRESP <= bresp_cfg;
                got_aw <= 1'b0; got_w <= 1'b0;
            end else begin
                got_aw <= aw_ok; got_w <= w_ok;
            end
            if (RVALID && RREADY) begin
                RVALID <= 1'b0;
                if (r_idx < 7) r_idx <= r_idx + 1;
            end
            if (ARVALID && ARREADY) begin
                if (r_delay == 0) begin
                    RVALID <= 1'b1; RDATA <= rd_data[r_idx]; RRESP <= rd_resp[r_idx];
                end else begin
                    r_pend <= 1'b1; r_cnt <= 1;
                end
            end else if (r_pend) begin
                if (r_cnt >= r_delay) begin
                    RVALID <= 1'b1; RDATA <= rd_data[r_idx]; RRESP <= rd_resp[r_idx];
                    r_pend <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
            if (mon_clr) r_idx <= 0;
        end
    end

    // Bus monitor
    int            cyc, aw_hs, w_hs, b_hs, ar_hs, awv_cyc, wv_cyc, chg;
    int            ar_t [8];
    logic [AW-1:0] awaddr_hs;
    logic [31:0]   wdata_hs;
    logic [3:0]    wstrb_hs;
    logic          aw_wait, w_wait;
    logic [AW-1:0] awaddr_prev;
    logic [31:0]   wdata_prev;

    always @(posedge ACLK) begin
        if (ARESET || mon_clr) begin
            cyc <= 0; aw_hs <= 0; w_hs <= 0; b_hs <= 0; ar_hs <= 0;
            awv_cyc <= 0; wv_cyc <= 0; chg <= 0;
            aw_wait <= 1'b0; w_wait <= 1'b0;
            for (int i = 0; i < 8; i++) ar_t[i] <= 0;
        end else begin
            cyc <= cyc + 1;
            if (AWVALID) awv_cyc <= awv_cyc + 1;
            if (WVALID)  wv_cyc <= wv_cyc + 1;
            if (AWVALID && AWREADY) begin
                aw_hs <= aw_hs + 1; awaddr_hs <= AWADDR;
            end
            if (WVALID && WREADY) begin
                w_hs <= w_hs + 1; wdata_hs <= WDATA; wstrb_hs <= WSTRB;
            end
            if (BVALID && BREADY) b_hs <= b_hs + 1;
            if (ARVALID && ARREADY) begin
                ar_hs <= ar_hs + 1;
                if (ar_hs < 8) ar_t[ar_hs] <= cyc;
            end
            if ((aw_wait && AWADDR != awaddr_prev) || (w_wait && WDATA != wdata_prev))
                chg <= chg + 1;
            aw_wait     <= AWVALID && !AWREADY;
            w_wait      <= WVALID && !WREADY;
            awaddr_prev <= AWADDR;
            wdata_prev  <= WDATA;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge ACLK);
        mon_clr = 1'b1;
        @(posedge ACLK);
        #1 mon_clr = 1'b0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [31:0] wd, input logic [3:0] ws);
        int n = 0;
        @(negedge ACLK);
        cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        check_eq("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
    endtask

    // lat is the cycle index (accept cycle = 0) where rsp_valid is first seen.
    task automatic wait_rsp(input int hold, output logic [31:0] rd, output logic [1:0] st,
                            output logic [15:0] pc, output int lat);
        lat = 0;
        rsp_ready = 1'b0;
        do begin
            @(negedge ACLK);
            lat++;
        end while (!rsp_valid && lat < 2000);
        check_eq("rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (hold) @(negedge ACLK);
        if (hold > 0) check_eq("rsp_hold", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata; st = rsp_status; pc = rsp_polls;
        rsp_ready = 1'b1;
        @(posedge ACLK);
        #1 rsp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  st;
    logic [15:0] pc;
    int          lat;

    initial begin
        for (int i = 0; i < 8; i++) begin
            rd_data[i] = '0;
            rd_resp[i] = 2'b00;
        end
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_eq("reset_ctrl", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready}),
                 32'd0);
        check_eq("reset_data", 32'({AWADDR, ARADDR}) | WDATA | 32'(WSTRB), 32'd0);
        ARESET = 1'b0;
        check_eq("rdy_at_release", 32'(cmd_ready), 32'd0);
        @(negedge ACLK);
        check_eq("rdy_after_release", 32'(cmd_ready), 32'd1);

        // Write, AWREADY delayed 3 cycles, WREADY immediate
        aw_delay = 3;
        clear_mon();
        send_cmd(2'b01, 6'h10, 32'hC0A8_0001, 4'hF);
        wait_rsp(0, rd, st, pc, lat);
        check_eq("wr_status", 32'(st), 32'd0);
        check_eq("wr_rdata", rd, 32'd0);
        check_eq("wr_polls", 32'(pc), 32'd0);
        check_eq("wr_awv_cycles", 32'(awv_cyc), 32'd4);
        check_eq("wr_wv_cycles", 32'(wv_cyc), 32'd1);
        check_eq("wr_b_hs", 32'(b_hs), 32'd1);
        check_eq("wr_aw_hs", 32'(aw_hs), 32'd1);
        check_eq("wr_awaddr", 32'(awaddr_hs), 32'h10);
        check_eq("wr_wdata", wdata_hs, 32'hC0A8_0001);
        check_eq("wr_wstrb", 32'(wstrb_hs), 32'hF);
        check_eq("wr_stable", 32'(chg), 32'd0);

        // Write latency with an always-ready slave
        aw_delay = 0;
        clear_mon();
        send_cmd(2'b01, 6'h04, 32'h0000_0001, 4'h1);
        wait_rsp(0, rd, st, pc, lat);
        check_eq("wr_latency", 32'(lat), 32'd3);
        check_eq("wr2_wstrb", 32'(wstrb_hs), 32'h1);

        // Read, RVALID delayed 2 cycles, response held 3 cycles
        r_delay = 2;
        rd_data[0] = 32'h0000_0004;
        clear_mon();
        send_cmd(2'b00, 6'h00, 32'h0, 4'h0);
        wait_rsp(3, rd, st, pc, lat);
        check_eq("rd_rdata", rd, 32'h4);
        check_eq("rd_status", 32'(st), 32'd0);
        check_eq("rd_polls", 32'(pc), 32'd0);
        check_eq("rd_ar_hs", 32'(ar_hs), 32'd1);

        // Reserved op read: latency and no write traffic
        r_delay = 0;
        rd_data[0] = 32'hDEAD_BEEF;
        clear_mon();
        send_cmd(2'b11, 6'h08, 32'h0, 4'h0);
        wait_rsp(0, rd, st, pc, lat);
        check_eq("rd11_latency", 32'(lat), 32'd3);
        check_eq("rd11_rdata", rd, 32'hDEAD_BEEF);
        check_eq("rd11_aw_hs", 32'(aw_hs), 32'd0);

        // Poll mask 0x2, data 4,4,6
        rd_data[0] = 32'h4; rd_data[1] = 32'h4; rd_data[2] = 32'h6;
        clear_mon();
        send_cmd(2'b10, 6'h00, 32'h2, 4'h0);
        wait_rsp(0, rd, st, pc, lat);
        check_eq("poll_rdata", rd, 32'h6);
        check_eq("poll_count", 32'(pc), 32'd3);
        check_eq("poll_status", 32'(st), 32'd0);
        check_eq("poll_ar_hs", 32'(ar_hs), 32'd3);
        check_eq("poll_gap01", 32'(ar_t[1] - ar_t[0]), 32'(GAP + 2));
        check_eq("poll_gap12", 32'(ar_t[2] - ar_t[1]), 32'(GAP + 2));

        // Poll timeout, slave always returns 0
        for (int i = 0; i < 8; i++) rd_data[i] = '0;
        clear_mon();
        send_cmd(2'b10, 6'h00, 32'h1, 4'h0);
        wait_rsp(0, rd, st, pc, lat);
        repeat (10) @(negedge ACLK);
        check_eq("to_status", 32'(st), 32'd2);
        check_eq("to_polls", 32'(pc), 32'(PMAX));
        check_eq("to_ar_hs", 32'(ar_hs), 32'(PMAX));

        // Mask 0 never matches
        for (int i = 0; i < 8; i++) rd_data[i] = 32'hFFFF_FFFF;
        clear_mon();
        send_cmd(2'b10, 6'h00, 32'h0, 4'h0);
        wait_rsp(0, rd, st, pc, lat);
        check_eq("m0_status", 32'(st), 32'd2);
        check_eq("m0_polls", 32'(pc), 32'(PMAX));
        check_eq("m0_rdata", rd, 32'hFFFF_FFFF);

        // Write error response
        bresp_cfg = 2'b10;
        clear_mon();
        send_cmd(2'b01, 6'h0C, 32'h5, 4'hF);
        wait_rsp(0, rd, st, pc, lat);
        check_eq("wrerr_status", 32'(st), 32'd1);
        bresp_cfg = 2'b00;

        // RRESP error on the second poll read aborts the poll
        for (int i = 0; i < 8; i++) rd_data[i] = '0;
        rd_resp[1] = 2'b11;
        clear_mon();
        send_cmd(2'b10, 6'h00, 32'h2, 4'h0);
        wait_rsp(0, rd, st, pc, lat);
        repeat (10) @(negedge ACLK);
        check_eq("rderr_status", 32'(st), 32'd1);
        check_eq("rderr_polls", 32'(pc), 32'd2);
        check_eq("rderr_ar_hs", 32'(ar_hs), 32'd2);
        rd_resp[1] = 2'b00;

        // Reset while waiting in RD_RESP
        r_delay = 50;
        clear_mon();
        send_cmd(2'b00, 6'h0C, 32'h0, 4'h0);
        @(negedge ACLK);
        @(negedge ACLK);
        check_eq("mid_rready", 32'(RREADY), 32'd1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check_eq("mid_reset_out", 32'({ARVALID, RREADY, rsp_valid, cmd_ready}), 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check_eq("mid_rdy_after", 32'(cmd_ready), 32'd1);
        r_delay = 0;
        clear_mon();
        send_cmd(2'b01, 6'h14, 32'h1234_5678, 4'h3);
        wait_rsp(0, rd, st, pc, lat);
        check_eq("post_status", 32'(st), 32'd0);
        check_eq("post_b_hs", 32'(b_hs), 32'd1);
        check_eq("post_wdata", wdata_hs, 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/axil_ctrl_master.md
Name: axil_ctrl_master

Overview:
AXI4-Lite initiator that drives the kernel control slave (ap_ctrl/GIE/IER/ISR/argument registers) from a simple command/response stream. It executes single register reads, writes, and bounded polls (repeated reads until a masked bit is set, e.g. ap_done). It sits in the on-chip test/bring-up path, replacing host-side register access. One transaction is outstanding at a time.

Parameters:
C_M_AXI_ADDR_WIDTH, 6, AXI address width.
C_M_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported).
POLL_GAP, 8, idle cycles between consecutive poll reads (>=0).
POLL_MAX, 1024, maximum poll reads before timeout (1..65535).

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  00 read, 01 write, 10 poll, 11 reserved (treated as read)
cmd_addr  in  C_M_AXI_ADDR_WIDTH  register byte address
cmd_wdata  in  32  write data; poll mask for op=10
cmd_wstrb  in  4  write strobes (ignored for read/poll)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  32  read data (last read for poll; 0 for write)
rsp_status  out  2  00 OK, 01 AXI error (non-zero BRESP/RRESP), 10 poll timeout
rsp_polls  out  16  number of poll reads issued (0 for read/write)
AWADDR  out  C_M_AXI_ADDR_WIDTH
AWVALID  out  1
AWREADY  in  1
WDATA  out  32
WSTRB  out  4
WVALID  out  1
WREADY  in  1
BRESP  in  2
BVALID  in  1
BREADY  out  1
ARADDR  out  C_M_AXI_ADDR_WIDTH
ARVALID  out  1
ARREADY  in  1
RDATA  in  32
RRESP  in  2
RVALID  in  1
RREADY  out  1

Behaviour:
- Reset: all VALID/READY outputs and rsp_valid 0; cmd_ready 0 during reset, 1 the cycle after; address/data outputs 0; state IDLE; counters 0.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, POLL_GAP, RSP.
- IDLE: cmd_ready=1. On handshake, latch cmd fields, clear poll count; op=01 -> WR_REQ; op=00/11 -> RD_REQ; op=10 -> RD_REQ with poll flag set.
- WR_REQ: AWVALID and WVALID both asserted the cycle after acceptance; each deasserts independently on its own handshake (AWREADY/WREADY may arrive in either order or the same cycle); AWADDR/WDATA/WSTRB stable while VALID. When both done -> WR_RESP.
- WR_RESP: BREADY=1; on BVALID capture BRESP; status=01 if BRESP!=0 else 00; -> RSP.
- RD_REQ: ARVALID=1, ARADDR stable; on ARREADY -> RD_RESP; poll count increments on AR handshake.
- RD_RESP: RREADY=1; on RVALID capture RDATA. RRESP!=0 -> status 01, RSP (poll aborts). Plain read -> status 00, RSP. Poll: (RDATA & mask)!=0 -> status 00, RSP; else count==POLL_MAX -> status 10, RSP; else POLL_GAP (or RD_REQ directly if POLL_GAP=0).
- POLL_GAP: count down POLL_GAP cycles, then RD_REQ.
- RSP: rsp_valid=1, outputs stable until rsp_ready; then IDLE. cmd_ready=0 in every non-IDLE state.
- Latency with always-ready slave: write accept->rsp_valid = 3 cycles; read = 3 cycles.
- VALID never depends combinationally on READY; once asserted, VALID held until handshake (AXI rule).
- Mask 0 poll: never matches, ends in timeout after POLL_MAX reads.
- Reset mid-transaction: all outputs return to reset values next cycle; in-flight AXI transfer abandoned (slave is reset together).

Test Plan:
- Write op=01 addr 0x10 data 0xC0A80001 strb 0xF, AWREADY delayed 3 cycles, WREADY immediate, BRESP=00 -> AWVALID held 4 cycles, WVALID 1 cycle, single B handshake, rsp status 00, rdata 0, polls 0.
- Read op=00 addr 0x00, slave returns 0x00000004 after 2-cycle RVALID delay -> rsp_rdata 0x4, status 00; ARVALID exactly one handshake.
- Poll op=10 addr 0x00 mask 0x2, slave returns 0x4,0x4,0x6 -> 3 AR handshakes spaced >=POLL_GAP+... cycles, rsp_rdata 0x6, polls 3, status 00.
- Poll timeout with POLL_MAX=4, slave always returns 0 -> exactly 4 reads, status 10, polls 4.
- Write with BRESP=2'b10 -> status 01; read with RRESP=2'b11 during poll -> immediate status 01, no further reads.
- ARESET asserted while in RD_RESP with rsp_ready held low -> next cycle ARVALID/RREADY/rsp_valid 0, cmd_ready 1 cycle after reset release; new write completes normally.
